// File: rtl/spi_slave_fifo.sv
// SPI slave oversampled in the system clock domain, with TX/RX FIFOs on a sel/we/address bus.
// Define SPI_SLV_MODE_SEL_EN for runtime CPOL/CPHA selection; otherwise the slave is fixed to mode 0.

module spi_slave_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int ADDR_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic [ADDR_W-1:0] address,
   input  logic              we,
   input  logic              sel,
   output logic              interrupt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = $clog2(DATA_W);
   localparam int LVL_W = DEPTH_LOG2 + 1;

   // Index 0/1 are the synchroniser stages, index 2 is the edge-detect history.
   logic [2:0] sclkSync_q, ssSync_q;
   logic [1:0] mosiSync_q;

   logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
   logic [DATA_W-1:0] rxShift_q, rxShift_d, txShift_q, txShift_d;
   logic              skip_q, skip_d;
   logic [LVL_W-1:0]  rxWr_q, rxRd_q, txWr_q, txRd_q;
   logic [DATA_W-1:0] rxMem [DEPTH];
   logic [DATA_W-1:0] txMem [DEPTH];
   logic              done_q, rxOvf_q, txUdf_q, irqRxEn_q, irqDoneEn_q, miso_q;

   logic sclkRise, sclkFall, ssFall, ssRise, inFrame, sampleEdge, shiftEdge, loadCpha;
   logic rxPush, txLoad, doneSet, flagClr, ctrlWr;
   logic rxPushEn, rxPopEn, txPushEn, txPopEn;
   logic [LVL_W-1:0] rxLevel, txLevel;
   logic rxEmpty, rxFull, txEmpty, txFull;
   logic [DATA_W-1:0] rxHead, txHead;
   logic [1:0] modeBits;
   logic [7:0] statusVec, ctrlVec;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclkSync_q <= '0;
         ssSync_q   <= '1;
         mosiSync_q <= '0;
      end else begin
         sclkSync_q <= {sclkSync_q[1:0], sclk};
         ssSync_q   <= {ssSync_q[1:0], ss};
         mosiSync_q <= {mosiSync_q[0], mosi};
      end
   end

   assign sclkRise = sclkSync_q[1] & ~sclkSync_q[2];
   assign sclkFall = ~sclkSync_q[1] & sclkSync_q[2];
   assign ssFall   = ~ssSync_q[1] & ssSync_q[2];
   assign ssRise   = ssSync_q[1] & ~ssSync_q[2];
   assign inFrame  = ~ssSync_q[1] & ~ssSync_q[2];

   assign ctrlWr  = sel & we & (address == ADDR_W'(3));
   assign flagClr = ctrlWr & data_in[4];

`ifdef SPI_SLV_MODE_SEL_EN
   // The programmed mode only becomes active at the next ss fall.
   logic [1:0] ctrlMode_q, modeAct_q;
   logic       leadEdge, trailEdge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrlMode_q <= '0;
         modeAct_q  <= '0;
      end else begin
         if (ctrlWr) ctrlMode_q <= data_in[3:2];
         if (ssFall) modeAct_q  <= ctrlMode_q;
      end
   end

   assign leadEdge   = modeAct_q[1] ? sclkFall : sclkRise;
   assign trailEdge  = modeAct_q[1] ? sclkRise : sclkFall;
   assign sampleEdge = modeAct_q[0] ? trailEdge : leadEdge;
   assign shiftEdge  = modeAct_q[0] ? leadEdge : trailEdge;
   assign loadCpha   = ctrlMode_q[0];
   assign modeBits   = ctrlMode_q;
`else
   assign sampleEdge = sclkRise;
   assign shiftEdge  = sclkFall;
   assign loadCpha   = 1'b0;
   assign modeBits   = 2'b00;
`endif

   assign rxLevel = rxWr_q - rxRd_q;
   assign txLevel = txWr_q - txRd_q;
   assign rxEmpty = (rxLevel == '0);
   assign txEmpty = (txLevel == '0);
   assign rxFull  = (rxLevel == LVL_W'(DEPTH));
   assign txFull  = (txLevel == LVL_W'(DEPTH));
   assign rxHead  = rxMem[rxRd_q[DEPTH_LOG2-1:0]];
   assign txHead  = txMem[txRd_q[DEPTH_LOG2-1:0]];

   // A freshly loaded word must survive the next shift edge so its MSB is seen first.
   always_comb begin
      bitCnt_d  = bitCnt_q;
      rxShift_d = rxShift_q;
      txShift_d = txShift_q;
      skip_d    = skip_q;
      rxPush    = 1'b0;
      txLoad    = 1'b0;
      doneSet   = 1'b0;
      if (ssFall) begin
         bitCnt_d = '0;
         txLoad   = 1'b1;
         skip_d   = loadCpha;
      end else if (ssRise) begin
         bitCnt_d = '0;
         doneSet  = 1'b1;
      end else if (inFrame) begin
         if (sampleEdge) begin
            rxShift_d = {rxShift_q[DATA_W-2:0], mosiSync_q[1]};
            if (bitCnt_q == CNT_W'(DATA_W-1)) begin
               bitCnt_d = '0;
               rxPush   = 1'b1;
               txLoad   = 1'b1;
               skip_d   = 1'b1;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         if (shiftEdge) begin
            if (skip_q) skip_d = 1'b0;
            else        txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
         end
      end
      if (txLoad) txShift_d = txEmpty ? '0 : txHead;
   end

   assign rxPushEn = rxPush & ~rxFull;
   assign rxPopEn  = sel & ~we & (address == ADDR_W'(2)) & ~rxEmpty;
   assign txPushEn = sel & we & (address == ADDR_W'(1)) & ~txFull;
   assign txPopEn  = txLoad & ~txEmpty;

   always_ff @(posedge clk) begin
      if (rxPushEn) rxMem[rxWr_q[DEPTH_LOG2-1:0]] <= rxShift_d;
      if (txPushEn) txMem[txWr_q[DEPTH_LOG2-1:0]] <= data_in;
   end

   // Flag set wins over a simultaneous CTRL clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitCnt_q    <= '0;
         rxShift_q   <= '0;
         txShift_q   <= '0;
         skip_q      <= 1'b0;
         rxWr_q      <= '0;
         rxRd_q      <= '0;
         txWr_q      <= '0;
         txRd_q      <= '0;
         done_q      <= 1'b0;
         rxOvf_q     <= 1'b0;
         txUdf_q     <= 1'b0;
         irqRxEn_q   <= 1'b0;
         irqDoneEn_q <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         bitCnt_q  <= bitCnt_d;
         rxShift_q <= rxShift_d;
         txShift_q <= txShift_d;
         skip_q    <= skip_d;
         rxWr_q    <= rxWr_q + LVL_W'(rxPushEn);
         rxRd_q    <= rxRd_q + LVL_W'(rxPopEn);
         txWr_q    <= txWr_q + LVL_W'(txPushEn);
         txRd_q    <= txRd_q + LVL_W'(txPopEn);
         done_q    <= (done_q & ~flagClr) | doneSet;
         rxOvf_q   <= (rxOvf_q & ~flagClr) | (rxPush & rxFull);
         txUdf_q   <= (txUdf_q & ~flagClr) | (txLoad & txEmpty);
         if (ctrlWr) begin
            irqRxEn_q   <= data_in[0];
            irqDoneEn_q <= data_in[1];
         end
         miso_q <= ~ssSync_q[1] & txShift_q[DATA_W-1];
      end
   end

   assign statusVec = {done_q, rxOvf_q, txUdf_q, txFull, txEmpty, rxFull, rxEmpty, ~ssSync_q[1]};
   assign ctrlVec   = {4'b0000, modeBits, irqDoneEn_q, irqRxEn_q};

   always_comb begin
      data_out = '0;
      case (address)
         ADDR_W'(0): data_out = DATA_W'(statusVec);
         ADDR_W'(2): data_out = rxEmpty ? '0 : rxHead;
         ADDR_W'(3): data_out = DATA_W'(ctrlVec);
         ADDR_W'(4): data_out = DATA_W'({txLevel, rxLevel});
         default:    data_out = '0;
      endcase
   end

   assign miso      = miso_q;
   assign interrupt = (irqRxEn_q & ~rxEmpty) | (irqDoneEn_q & done_q);

endmodule
